cmt_trace_buf: RTL and testbench



---
 rtl/cmt_trace_buf.sv | 177 +++++++++++++++++
 tb/tb_cmt_trace_buf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmt_trace_buf.sv
// cmt_trace_buf: multi-lane commit trace buffer.
// Valid commit lanes are compacted in ascending lane order into a circular
// buffer. A host reader drains it one record per valid/ready handshake.
// A group that does not fit is rejected whole and counted as dropped.
// Every record carries a sequence number, so drops show up as gaps in it.
// Legal parameter space: 1 <= NCMT <= 8, DEPTH a power of two, DEPTH >= 2*NCMT.

module cmt_trace_buf #(
  parameter int NCMT  = 4,
  parameter int DEPTH = 64,
  parameter int XLEN  = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_mode_drop,
  input  logic                          i_clear,
  input  logic [NCMT-1:0]               i_cmt,
  input  logic [NCMT-1:0][XLEN-1:0]     i_cmt_pc,
  input  logic [NCMT-1:0][31:0]         i_cmt_ir,
  input  logic [NCMT-1:0]               i_cmt_gprw,
  input  logic [NCMT-1:0][5:0]          i_cmt_gpra,
  input  logic [NCMT-1:0][XLEN-1:0]     i_cmt_gprv,
  input  logic [NCMT-1:0]               i_cmt_exc,
  output logic                          o_stall,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [XLEN-1:0]               o_out_pc,
  output logic [31:0]                   o_out_ir,
  output logic                          o_out_gprw,
  output logic [5:0]                    o_out_gpra,
  output logic [XLEN-1:0]               o_out_gprv,
  output logic                          o_out_exc,
  output logic [63:0]                   o_out_seq,
  output logic [$clog2(DEPTH):0]        o_level,
  output logic [31:0]                   o_dropped,
  output logic                          o_overflow
);

  // Pointer width and occupancy width (one extra bit separates full from empty).
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Storage array: one entry per record. Not reset; entries are only read
  // while the occupancy says they hold a live record.
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [31:0]     r_mem_ir   [DEPTH];
  logic            r_mem_gprw [DEPTH];
  logic [5:0]      r_mem_gpra [DEPTH];
  logic [XLEN-1:0] r_mem_gprv [DEPTH];
  logic            r_mem_exc  [DEPTH];
  logic [63:0]     r_mem_seq  [DEPTH];

  // Control state.
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [63:0]   r_seq_ctr;
  logic [31:0]   r_dropped;
  logic          r_overflow;

  // Per-lane slot offset inside the current group and the group size.
  logic [LW-1:0] w_off [NCMT];
  logic [LW-1:0] w_cnt;
  logic [LW-1:0] w_k;
  logic [LW-1:0] w_admit_k;
  logic [LW-1:0] w_level_nxt;
  logic          w_push_any;
  logic          w_fits;
  logic          w_admit;
  logic          w_reject;
  logic          w_pop;
  logic [32:0]   w_drop_sum;
  logic [31:0]   w_dropped_nxt;

  // Lane compaction: each valid lane's slot is the number of valid lanes below it.
  always_comb begin
    w_cnt = {LW{1'b0}};
    for (int i = 0; i < NCMT; i++) begin
      w_off[i] = w_cnt;
      if (i_cmt[i]) begin
        w_cnt = w_cnt + LW'(1'b1);
      end else begin
        w_cnt = w_cnt;
      end
    end
  end

  // Admission decision, pop detection and next-state arithmetic.
  always_comb begin
    // Commits are ignored entirely while capture is disabled.
    w_k         = i_enable ? w_cnt : {LW{1'b0}};
    w_push_any  = (w_k != {LW{1'b0}});
    // Decided on the registered level: a same-cycle pop does not make room.
    w_fits      = ((r_level + w_k) <= LW'(DEPTH));
    // A clear in the same cycle discards the group, which then counts as dropped.
    w_admit     = w_push_any & ~i_clear & w_fits;
    w_reject    = w_push_any & ~w_admit;
    w_admit_k   = w_admit ? w_k : {LW{1'b0}};
    w_pop       = o_out_valid & i_out_ready;
    w_level_nxt = r_level + w_admit_k - {{(LW-1){1'b0}}, w_pop};
    // Saturating drop counter.
    w_drop_sum  = {1'b0, r_dropped} + {{(33-LW){1'b0}}, w_k};
    if (w_drop_sum[32]) begin
      w_dropped_nxt = {32{1'b1}};
    end else begin
      w_dropped_nxt = w_drop_sum[31:0];
    end
  end

  // Pointer, occupancy, sequence and drop bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_seq_ctr  <= 64'd0;
      r_dropped  <= 32'd0;
      r_overflow <= 1'b0;
    end else begin
      if (i_clear) begin
        r_wr_ptr <= {PW{1'b0}};
        r_rd_ptr <= {PW{1'b0}};
        r_level  <= {LW{1'b0}};
      end else begin
        r_wr_ptr <= r_wr_ptr + w_admit_k[PW-1:0];
        r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, w_pop};
        r_level  <= w_level_nxt;
      end
      // The sequence counter advances for every captured group, admitted or not.
      if (w_push_any) begin
        r_seq_ctr <= r_seq_ctr + {{(64-LW){1'b0}}, w_k};
      end else begin
        r_seq_ctr <= r_seq_ctr;
      end
      if (w_reject) begin
        r_dropped  <= w_dropped_nxt;
        r_overflow <= 1'b1;
      end else begin
        r_dropped  <= r_dropped;
        r_overflow <= r_overflow;
      end
    end
  end

  // Record write: each valid lane lands at wr_ptr plus its compacted slot.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NCMT; i++) begin
      if (!i_rst && w_admit && i_cmt[i]) begin
        r_mem_pc  [r_wr_ptr + w_off[i][PW-1:0]] <= i_cmt_pc[i];
        r_mem_ir  [r_wr_ptr + w_off[i][PW-1:0]] <= i_cmt_ir[i];
        r_mem_gprw[r_wr_ptr + w_off[i][PW-1:0]] <= i_cmt_gprw[i];
        r_mem_gpra[r_wr_ptr + w_off[i][PW-1:0]] <= i_cmt_gpra[i];
        r_mem_gprv[r_wr_ptr + w_off[i][PW-1:0]] <= i_cmt_gprv[i];
        r_mem_exc [r_wr_ptr + w_off[i][PW-1:0]] <= i_cmt_exc[i];
        r_mem_seq [r_wr_ptr + w_off[i][PW-1:0]] <= r_seq_ctr + {{(64-LW){1'b0}}, w_off[i]};
      end
    end
  end

  // Status outputs come straight from registered state; stall ignores cmt.
  assign o_out_valid = (r_level != {LW{1'b0}});
  assign o_stall     = ~i_mode_drop & (r_level > LW'(DEPTH - NCMT));
  assign o_level     = r_level;
  assign o_dropped   = r_dropped;
  assign o_overflow  = r_overflow;

  // Head record is a direct read of the entry under the read pointer.
  assign o_out_pc   = r_mem_pc  [r_rd_ptr];
  assign o_out_ir   = r_mem_ir  [r_rd_ptr];
  assign o_out_gprw = r_mem_gprw[r_rd_ptr];
  assign o_out_gpra = r_mem_gpra[r_rd_ptr];
  assign o_out_gprv = r_mem_gprv[r_rd_ptr];
  assign o_out_exc  = r_mem_exc [r_rd_ptr];
  assign o_out_seq  = r_mem_seq [r_rd_ptr];

endmodule

// File: tb/tb_cmt_trace_buf.sv
// Directed testbench for cmt_trace_buf (NCMT=4, DEPTH=64, XLEN=64).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.

module tb_cmt_trace_buf;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              mode_drop;
  logic              clear;
  logic [3:0]        cmt;
  logic [3:0][63:0]  cmt_pc;
  logic [3:0][31:0]  cmt_ir;
  logic [3:0]        cmt_gprw;
  logic [3:0][5:0]   cmt_gpra;
  logic [3:0][63:0]  cmt_gprv;
  logic [3:0]        cmt_exc;
  logic              stall;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_pc;
  logic [31:0]       out_ir;
  logic              out_gprw;
  logic [5:0]        out_gpra;
  logic [63:0]       out_gprv;
  logic              out_exc;
  logic [63:0]       out_seq;
  logic [6:0]        level;
  logic [31:0]       dropped;
  logic              overflow;

  int checks;
  int errors;

  cmt_trace_buf #(.NCMT(4), .DEPTH(64), .XLEN(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_mode_drop(mode_drop),
    .i_clear(clear), .i_cmt(cmt), .i_cmt_pc(cmt_pc), .i_cmt_ir(cmt_ir),
    .i_cmt_gprw(cmt_gprw), .i_cmt_gpra(cmt_gpra), .i_cmt_gprv(cmt_gprv),
    .i_cmt_exc(cmt_exc), .o_stall(stall), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_pc(out_pc), .o_out_ir(out_ir),
    .o_out_gprw(out_gprw), .o_out_gpra(out_gpra), .o_out_gprv(out_gprv),
    .o_out_exc(out_exc), .o_out_seq(out_seq), .o_level(level),
    .o_dropped(dropped), .o_overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; mode_drop = 1'b0; clear = 1'b0; cmt = 4'b0000;
    cmt_pc = '0; cmt_ir = '0; cmt_gprw = 4'b0000; cmt_gpra = '0; cmt_gprv = '0;
    cmt_exc = 4'b0000; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (dropped !== 32'd0) begin errors++; $display("FAIL reset_dropped got %0d want 0", dropped); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single_lane();
    do_reset();
    out_ready = 1'b1;
    cmt = 4'b0001; cmt_pc[0] = 64'h8000_0000; cmt_ir[0] = 32'h0000_0013;
    tick();
    cmt = 4'b0000;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_pc !== 64'h8000_0000) begin errors++; $display("FAIL single_pc got %h want 80000000", out_pc); end
    checks++; if (out_ir !== 32'h0000_0013) begin errors++; $display("FAIL single_ir got %h want 00000013", out_ir); end
    checks++; if (out_seq !== 64'd0) begin errors++; $display("FAIL single_seq got %0d want 0", out_seq); end
    tick();
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL single_drain_level got %0d want 0", level); end
  endtask

  task automatic test_compaction();
    do_reset();
    cmt = 4'b1010;
    cmt_pc[1] = 64'h100; cmt_gprw[1] = 1'b1; cmt_gpra[1] = 6'd5; cmt_gprv[1] = 64'hAAAA;
    cmt_pc[3] = 64'h200; cmt_exc[3] = 1'b1;
    cmt_pc[0] = 64'hDEAD; cmt_pc[2] = 64'hBEEF;
    tick();
    cmt = 4'b0000;
    checks++; if (level !== 7'd2) begin errors++; $display("FAIL compact_level got %0d want 2", level); end
    checks++; if (out_pc !== 64'h100) begin errors++; $display("FAIL compact_pc0 got %h want 100", out_pc); end
    checks++; if (out_seq !== 64'd0) begin errors++; $display("FAIL compact_seq0 got %0d want 0", out_seq); end
    checks++; if (out_gprw !== 1'b1 || out_gpra !== 6'd5 || out_gprv !== 64'hAAAA || out_exc !== 1'b0)
      begin errors++; $display("FAIL compact_gpr got w=%b a=%0d v=%h e=%b want 1 5 aaaa 0", out_gprw, out_gpra, out_gprv, out_exc); end
    tick();
    checks++; if (out_pc !== 64'h100) begin errors++; $display("FAIL hold_pc got %h want 100", out_pc); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 64'h200 || out_seq !== 64'd1) begin errors++; $display("FAIL compact_rec1 got pc=%h seq=%0d want 200 1", out_pc, out_seq); end
    checks++; if (out_exc !== 1'b1 || out_gprw !== 1'b0) begin errors++; $display("FAIL compact_rec1_flags got e=%b w=%b want 1 0", out_exc, out_gprw); end
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL compact_level1 got %0d want 1", level); end
    tick();
    enable = 1'b0; cmt = 4'b1111;
    tick();
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL disabled_level got %0d want 0", level); end
    enable = 1'b1; cmt = 4'b0100; cmt_pc[2] = 64'h300;
    tick();
    cmt = 4'b0000;
    checks++; if (out_pc !== 64'h300 || out_seq !== 64'd2) begin errors++; $display("FAIL disabled_seq got pc=%h seq=%0d want 300 2", out_pc, out_seq); end
  endtask

  task automatic test_stall_mode();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cmt = 4'b1111;
      tick();
    end
    checks++; if (level !== 7'd60) begin errors++; $display("FAIL stall_level60 got %0d want 60", level); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_at60 got %b want 0", stall); end
    tick();
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL stall_level64 got %0d want 64", level); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_at64 got %b want 1", stall); end
    cmt = 4'b0001; cmt_pc[0] = 64'h999;
    tick();
    checks++; if (dropped !== 32'd1 || overflow !== 1'b1) begin errors++; $display("FAIL stall_drop got d=%0d o=%b want 1 1", dropped, overflow); end
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL stall_reject_level got %0d want 64", level); end
    cmt = 4'b0000; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; cmt = 4'b0001; cmt_pc[0] = 64'hABC;
    tick();
    cmt = 4'b0000; out_ready = 1'b1;
    for (int j = 0; j < 63; j++) begin
      checks++; if (out_seq !== 64'(j + 1)) begin errors++; $display("FAIL stall_drain_seq got %0d want %0d", out_seq, j + 1); end
      tick();
    end
    checks++; if (out_seq !== 64'd65 || out_pc !== 64'hABC) begin errors++; $display("FAIL stall_next_seq got seq=%0d pc=%h want 65 abc", out_seq, out_pc); end
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL stall_drain_level got %0d want 1", level); end
  endtask

  task automatic test_drop_mode();
    do_reset();
    mode_drop = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cmt = 4'b1111;
      tick();
    end
    cmt = 4'b0011;
    tick();
    checks++; if (level !== 7'd62) begin errors++; $display("FAIL drop_level62 got %0d want 62", level); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drop_stall got %b want 0", stall); end
    cmt = 4'b1111; out_ready = 1'b1;
    tick();
    checks++; if (level !== 7'd61) begin errors++; $display("FAIL drop_level61 got %0d want 61", level); end
    checks++; if (dropped !== 32'd4 || overflow !== 1'b1) begin errors++; $display("FAIL drop_count got d=%0d o=%b want 4 1", dropped, overflow); end
    cmt = 4'b0111; out_ready = 1'b0;
    tick();
    cmt = 4'b0000;
    checks++; if (level !== 7'd64 || dropped !== 32'd4) begin errors++; $display("FAIL drop_exact_fit got l=%0d d=%0d want 64 4", level, dropped); end
  endtask

  task automatic test_wrap();
    int sent;
    int exp_seq;
    int cyc;
    do_reset();
    sent = 0; exp_seq = 0; cyc = 0;
    while (exp_seq < 200 && cyc < 3000) begin
      out_ready = cyc[0];
      if (sent < 200 && stall == 1'b0) begin
        cmt = 4'b0001; cmt_pc[0] = 64'h1000 + 64'(4 * sent); sent++;
      end else begin
        cmt = 4'b0000;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_seq !== 64'(exp_seq) || out_pc !== 64'h1000 + 64'(4 * exp_seq)) begin
          errors++; $display("FAIL wrap_rec got seq=%0d pc=%h want %0d %h", out_seq, out_pc, exp_seq, 64'h1000 + 64'(4 * exp_seq));
        end
        exp_seq++;
      end
      tick();
      cyc++;
    end
    cmt = 4'b0000; out_ready = 1'b0;
    checks++; if (exp_seq != 200) begin errors++; $display("FAIL wrap_count got %0d want 200", exp_seq); end
    checks++; if (dropped !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL wrap_nodrop got d=%0d o=%b want 0 0", dropped, overflow); end
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL wrap_level got %0d want 0", level); end
  endtask

  task automatic test_clear();
    do_reset();
    cmt = 4'b0011;
    tick();
    clear = 1'b1; cmt = 4'b0011;
    tick();
    clear = 1'b0;
    checks++; if (level !== 7'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clear_level got l=%0d v=%b want 0 0", level, out_valid); end
    checks++; if (dropped !== 32'd2 || overflow !== 1'b1) begin errors++; $display("FAIL clear_drop got d=%0d o=%b want 2 1", dropped, overflow); end
    cmt = 4'b0001; cmt_pc[0] = 64'h55;
    tick();
    cmt = 4'b0000;
    checks++; if (out_seq !== 64'd4 || out_pc !== 64'h55) begin errors++; $display("FAIL clear_seq got seq=%0d pc=%h want 4 55", out_seq, out_pc); end
  endtask

  task automatic test_back_to_back_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmt = 4'b1111;
      tick();
    end
    rst = 1'b1;
    tick();
    checks++; if (level !== 7'd0 || out_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL midrst_state got l=%0d v=%b s=%b want 0 0 0", level, out_valid, stall); end
    checks++; if (dropped !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_drop got d=%0d o=%b want 0 0", dropped, overflow); end
    rst = 1'b0; cmt = 4'b0001; cmt_pc[0] = 64'h77; out_ready = 1'b0;
    tick();
    cmt = 4'b0000;
    checks++; if (out_seq !== 64'd0 || out_pc !== 64'h77) begin errors++; $display("FAIL midrst_seq got seq=%0d pc=%h want 0 77", out_seq, out_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_lane();
    test_compaction();
    test_stall_mode();
    test_drop_mode();
    test_wrap();
    test_clear();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
